// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared opcode/command encodings, FSM state type and decode helpers for control_sequencer.
// Build option CONTROL_SEQUENCER_ROT3_EN adds the 3-step ROT3 macro at opcode 111110.
package cpu_ctrl_pkg;

    localparam logic [5:0] OP_NOP  = 6'b000000;
    localparam logic [5:0] OP_ADD  = 6'b000001;
    localparam logic [5:0] OP_SUB  = 6'b000011;
    localparam logic [5:0] OP_AND  = 6'b000101;
    localparam logic [5:0] OP_OR   = 6'b000110;
    localparam logic [5:0] OP_NOR  = 6'b000111;
    localparam logic [5:0] OP_XOR  = 6'b001000;
    localparam logic [5:0] OP_SLA  = 6'b001001;
    localparam logic [5:0] OP_SLL  = 6'b001010;
    localparam logic [5:0] OP_SRA  = 6'b001011;
    localparam logic [5:0] OP_SRL  = 6'b001100;
    localparam logic [5:0] OP_ADDI = 6'b100000;
    localparam logic [5:0] OP_SUBI = 6'b100001;
    localparam logic [5:0] OP_LD   = 6'b100100;
    localparam logic [5:0] OP_ST   = 6'b100101;
    localparam logic [5:0] OP_BEZ  = 6'b101000;
    localparam logic [5:0] OP_BNE  = 6'b101001;
    localparam logic [5:0] OP_JMP  = 6'b101010;
    localparam logic [5:0] OP_ROT3 = 6'b111110;
    localparam logic [5:0] OP_SWP  = 6'b111111;

    localparam logic [3:0] CMD_ADD = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_AND = 4'b0100;
    localparam logic [3:0] CMD_OR  = 4'b0101;
    localparam logic [3:0] CMD_NOR = 4'b0110;
    localparam logic [3:0] CMD_XOR = 4'b0111;
    localparam logic [3:0] CMD_SLL = 4'b1000;
    localparam logic [3:0] CMD_SRA = 4'b1001;
    localparam logic [3:0] CMD_SRL = 4'b1010;
    localparam logic [3:0] CMD_MAC = 4'b1100;

    localparam logic [1:0] BR_NONE = 2'b00;
    localparam logic [1:0] BR_BEZ  = 2'b01;
    localparam logic [1:0] BR_BNE  = 2'b10;
    localparam logic [1:0] BR_JMP  = 2'b11;

    localparam logic [1:0] SWP_NONE = 2'b00;
    localparam logic [1:0] SWP_A    = 2'b01;
    localparam logic [1:0] SWP_B    = 2'b10;
    localparam logic [1:0] SWP_C    = 2'b11;

`ifdef CONTROL_SEQUENCER_ROT3_EN
    localparam int MIN_STEPS = 3;
`else
    localparam int MIN_STEPS = 2;
`endif

    typedef enum logic {IDLE, SEQ} state_t;

    typedef struct packed {
        logic [3:0] cmd;
        logic       mem_r;
        logic       mem_w;
        logic       wb;
        logic       imm;
        logic       single;
        logic [1:0] br;
        logic       illegal;
    } ctrl_t;

    // Zero means "not a macro opcode".
    function automatic logic [2:0] macro_steps(input logic [5:0] op);
`ifdef CONTROL_SEQUENCER_ROT3_EN
        return op == OP_SWP ? 3'd2 : op == OP_ROT3 ? 3'd3 : 3'd0;
`else
        return op == OP_SWP ? 3'd2 : 3'd0;
`endif
    endfunction

    // Single-cycle decode; macro opcodes decode to all-zero but legal.
    function automatic ctrl_t decode(input logic [5:0] op);
        ctrl_t c;
        c = '0;
        case (op)
            OP_NOP: ;
            OP_ADD: begin c.cmd = CMD_ADD; c.wb = 1'b1; end
            OP_SUB: begin c.cmd = CMD_SUB; c.wb = 1'b1; end
            OP_AND: begin c.cmd = CMD_AND; c.wb = 1'b1; end
            OP_OR:  begin c.cmd = CMD_OR;  c.wb = 1'b1; end
            OP_NOR: begin c.cmd = CMD_NOR; c.wb = 1'b1; end
            OP_XOR: begin c.cmd = CMD_XOR; c.wb = 1'b1; end
            OP_SLA, OP_SLL: begin c.cmd = CMD_SLL; c.wb = 1'b1; end
            OP_SRA: begin c.cmd = CMD_SRA; c.wb = 1'b1; end
            OP_SRL: begin c.cmd = CMD_SRL; c.wb = 1'b1; end
            OP_ADDI: begin c.cmd = CMD_ADD; c.imm = 1'b1; c.wb = 1'b1; c.single = 1'b1; end
            OP_SUBI: begin c.cmd = CMD_SUB; c.imm = 1'b1; c.wb = 1'b1; c.single = 1'b1; end
            OP_LD:  begin c.imm = 1'b1; c.mem_r = 1'b1; c.wb = 1'b1; c.single = 1'b1; end
            OP_ST:  begin c.imm = 1'b1; c.mem_w = 1'b1; end
            OP_BEZ: begin c.imm = 1'b1; c.single = 1'b1; c.br = BR_BEZ; end
            OP_BNE: begin c.imm = 1'b1; c.br = BR_BNE; end
            OP_JMP: begin c.imm = 1'b1; c.single = 1'b1; c.br = BR_JMP; end
            OP_SWP: ;
`ifdef CONTROL_SEQUENCER_ROT3_EN
            OP_ROT3: ;
`endif
            default: c.illegal = 1'b1;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/macro_rom.sv
// macro_rom: maps (macro opcode, micro-step) to {exec_cmd, swp_sel, wb_en, last}.
// Ports: opcode/step in; exec_cmd, swp_sel, wb_en, last out (all zero for non-macro opcodes).
module macro_rom
    import cpu_ctrl_pkg::*;
#(
    parameter int SW = 2
) (
    input  logic [5:0]    opcode,
    input  logic [SW-1:0] step,
    output logic [3:0]    exec_cmd,
    output logic [1:0]    swp_sel,
    output logic          wb_en,
    output logic          last
);

    logic [2:0] n;

    // Every macro step k uses cmd 1100+k and selector k+1.
    always_comb begin
        n        = macro_steps(opcode);
        exec_cmd = n != 3'd0 ? CMD_MAC + 4'(step) : CMD_ADD;
        swp_sel  = n != 3'd0 ? 2'(step) + 2'd1 : SWP_NONE;
        wb_en    = n != 3'd0;
        last     = n != 3'd0 && 32'(step) + 32'd1 == 32'(n);
    end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: decode-stage control unit with stall-aware macro-op sequencer.
// Inputs: clk, rst_n (sync, active-low), opcode, stall_in.
// Outputs: exec_cmd, mem_r_en, mem_w_en, wb_en, is_imm, single_src, branch_type,
//          swp_sel, freeze, step, seq_done, illegal_op.
// Build option CONTROL_SEQUENCER_ROT3_EN enables the ROT3 macro (needs MAX_STEPS >= 3).
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int OPCODE_W  = 6,
    parameter int CMD_W     = 4,
    parameter int MAX_STEPS = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [OPCODE_W-1:0]          opcode,
    input  logic                         stall_in,
    output logic [CMD_W-1:0]             exec_cmd,
    output logic                         mem_r_en,
    output logic                         mem_w_en,
    output logic                         wb_en,
    output logic                         is_imm,
    output logic                         single_src,
    output logic [1:0]                   branch_type,
    output logic [1:0]                   swp_sel,
    output logic                         freeze,
    output logic [$clog2(MAX_STEPS)-1:0] step,
    output logic                         seq_done,
    output logic                         illegal_op
);

    localparam int SW = $clog2(MAX_STEPS);

    if (MAX_STEPS < MIN_STEPS) begin : g_steps_chk
        $error("MAX_STEPS too small for the enabled macro set");
    end

    state_t              state_q, state_d;
    logic [SW-1:0]       step_q, step_d;
    logic [OPCODE_W-1:0] op_q, op_d;
    logic [OPCODE_W-1:0] rom_op;
    logic [SW-1:0]       rom_step;
    logic [3:0]          rom_cmd;
    logic [1:0]          rom_sel;
    logic                rom_wb, rom_last, active, adv;
    ctrl_t               dec;

    macro_rom #(.SW(SW)) u_rom (
        .opcode   (rom_op),
        .step     (rom_step),
        .exec_cmd (rom_cmd),
        .swp_sel  (rom_sel),
        .wb_en    (rom_wb),
        .last     (rom_last)
    );

    // In SEQ the latched macro opcode drives the ROM; the live opcode is ignored.
    always_comb begin
        rom_op      = state_q == SEQ ? op_q : opcode;
        rom_step    = state_q == SEQ ? step_q : '0;
        active      = state_q == SEQ || macro_steps(opcode) != 3'd0;
        adv         = active && !stall_in;
        dec         = decode(opcode);
        exec_cmd    = !rst_n ? '0 : active ? rom_cmd : dec.cmd;
        swp_sel     = rst_n && active ? rom_sel : SWP_NONE;
        wb_en       = rst_n && !stall_in && (active ? rom_wb : dec.wb);
        mem_w_en    = rst_n && !stall_in && !active && dec.mem_w;
        mem_r_en    = rst_n && !active && dec.mem_r;
        is_imm      = rst_n && !active && dec.imm;
        single_src  = rst_n && !active && dec.single;
        branch_type = rst_n && !active ? dec.br : BR_NONE;
        illegal_op  = rst_n && !active && dec.illegal;
        freeze      = rst_n && active && (stall_in || !rom_last);
        seq_done    = rst_n && adv && rom_last;
        step        = rst_n ? step_q : '0;
        state_d     = adv ? (rom_last ? IDLE : SEQ) : state_q;
        step_d      = adv ? (rom_last ? '0 : step_q + SW'(1)) : step_q;
        op_d        = adv ? rom_op : op_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            step_q  <= '0;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            op_q    <= op_d;
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed and random stimulus checked against a queue-based reference model.
module tb_control_sequencer;

    logic       clk = 1'b0;
    logic       rst_n, stall_in;
    logic [5:0] opcode;
    logic [3:0] exec_cmd;
    logic       mem_r_en, mem_w_en, wb_en, is_imm, single_src, freeze, seq_done, illegal_op;
    logic [1:0] branch_type, swp_sel, step;

    int checks = 0;
    int errors = 0;

    logic [11:0] tab [64];
    int          pend[$];
    int          mn;
    logic [5:0]  pool [20];

    always #5 clk = ~clk;

    control_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .opcode      (opcode),
        .stall_in    (stall_in),
        .exec_cmd    (exec_cmd),
        .mem_r_en    (mem_r_en),
        .mem_w_en    (mem_w_en),
        .wb_en       (wb_en),
        .is_imm      (is_imm),
        .single_src  (single_src),
        .branch_type (branch_type),
        .swp_sel     (swp_sel),
        .freeze      (freeze),
        .step        (step),
        .seq_done    (seq_done),
        .illegal_op  (illegal_op)
    );

    function automatic int nsteps(input logic [5:0] op);
        if (op == 6'b111111) return 2;
`ifdef CONTROL_SEQUENCER_ROT3_EN
        if (op == 6'b111110) return 3;
`endif
        return 0;
    endfunction

    function automatic logic [11:0] ent(input logic [3:0] c, input logic r, w, wb, imm, sg,
                                        input logic [1:0] br);
        return {c, r, w, wb, imm, sg, br, 1'b0};
    endfunction

    // Caller is just after a rising edge: apply inputs, check mid-cycle, then advance the model.
    task automatic cyc(input logic [5:0] op, input logic st, input logic rn, input string tag);
        logic [17:0] exp, obs;
        logic [11:0] t;
        int          k, n;
        bit          mac, busy, last;
        opcode = op; stall_in = st; rst_n = rn;
        @(negedge clk);
        busy = pend.size() > 0;
        n    = busy ? mn : nsteps(op);
        mac  = busy || n > 0;
        k    = busy ? pend[0] : 0;
        last = mac && k == n - 1;
        t    = tab[op];
        if (!rn)
            exp = '0;
        else if (mac)
            exp = {4'(12 + k), 2'b00, !st, 2'b00, 2'b00, 2'(k + 1), st || !last, !st && last, 1'b0, 2'(k)};
        else
            exp = {t[11:8], t[7], t[6] & !st, t[5] & !st, t[4], t[3], t[2:1], 2'b00, 2'b00, t[0], 2'b00};
        obs = {exec_cmd, mem_r_en, mem_w_en, wb_en, is_imm, single_src, branch_type,
               swp_sel, freeze, seq_done, illegal_op, step};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s op=%b stall=%b rst_n=%b got=%b want=%b", tag, op, st, rn, obs, exp);
        end
        @(posedge clk);
        #1;
        if (!rn) pend.delete();
        else if (mac && !st) begin
            if (busy) pend.delete(0);
            else begin
                mn = n;
                for (int j = 1; j < n; j++) pend.push_back(j);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) tab[i] = 12'h001;
        tab[6'b000000] = ent(4'b0000, 0, 0, 0, 0, 0, 2'b00);
        tab[6'b000001] = ent(4'b0000, 0, 0, 1, 0, 0, 2'b00);
        tab[6'b000011] = ent(4'b0010, 0, 0, 1, 0, 0, 2'b00);
        tab[6'b000101] = ent(4'b0100, 0, 0, 1, 0, 0, 2'b00);
        tab[6'b000110] = ent(4'b0101, 0, 0, 1, 0, 0, 2'b00);
        tab[6'b000111] = ent(4'b0110, 0, 0, 1, 0, 0, 2'b00);
        tab[6'b001000] = ent(4'b0111, 0, 0, 1, 0, 0, 2'b00);
        tab[6'b001001] = ent(4'b1000, 0, 0, 1, 0, 0, 2'b00);
        tab[6'b001010] = ent(4'b1000, 0, 0, 1, 0, 0, 2'b00);
        tab[6'b001011] = ent(4'b1001, 0, 0, 1, 0, 0, 2'b00);
        tab[6'b001100] = ent(4'b1010, 0, 0, 1, 0, 0, 2'b00);
        tab[6'b100000] = ent(4'b0000, 0, 0, 1, 1, 1, 2'b00);
        tab[6'b100001] = ent(4'b0010, 0, 0, 1, 1, 1, 2'b00);
        tab[6'b100100] = ent(4'b0000, 1, 0, 1, 1, 1, 2'b00);
        tab[6'b100101] = ent(4'b0000, 0, 1, 0, 1, 0, 2'b00);
        tab[6'b101000] = ent(4'b0000, 0, 0, 0, 1, 1, 2'b01);
        tab[6'b101001] = ent(4'b0000, 0, 0, 0, 1, 0, 2'b10);
        tab[6'b101010] = ent(4'b0000, 0, 0, 0, 1, 1, 2'b11);
        tab[6'b111111] = 12'h000;
`ifdef CONTROL_SEQUENCER_ROT3_EN
        tab[6'b111110] = 12'h000;
`endif
        pool = '{6'h00, 6'h01, 6'h03, 6'h05, 6'h06, 6'h07, 6'h08, 6'h09, 6'h0A, 6'h0B,
                 6'h0C, 6'h20, 6'h21, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2A, 6'h3F, 6'h3E};

        opcode = 6'h01; stall_in = 1'b0; rst_n = 1'b0;
        @(posedge clk);
        #1;
        cyc(6'h01, 0, 0, "reset");
        cyc(6'h3F, 0, 0, "reset_swp");

        for (int i = 0; i < 62; i++) cyc(6'(i), 0, 1, "sweep");
        cyc(6'h15, 0, 1, "illegal_010101");
        cyc(6'h01, 1, 1, "add_stalled");
        cyc(6'h25, 1, 1, "st_stalled");

        cyc(6'h3F, 0, 1, "swp_s0");
        cyc(6'h01, 0, 1, "swp_s1");
        cyc(6'h01, 0, 1, "swp_after");

        cyc(6'h3F, 0, 1, "swp_stall_s0");
        cyc(6'h3F, 1, 1, "swp_stall_s1a");
        cyc(6'h3F, 1, 1, "swp_stall_s1b");
        cyc(6'h3F, 0, 1, "swp_stall_release");
        cyc(6'h3F, 1, 1, "swp_idle_stall");
        cyc(6'h3F, 0, 1, "swp_idle_stall_go");
        cyc(6'h3F, 0, 1, "swp_idle_stall_end");

        cyc(6'h3F, 0, 0, "swp_rst_s0");
        cyc(6'h01, 0, 1, "add_after_rst");
        cyc(6'h3F, 0, 1, "swp_mid_s0");
        cyc(6'h3F, 0, 0, "swp_mid_rst");
        cyc(6'h01, 0, 1, "add_after_mid_rst");

        for (int i = 0; i < 4; i++) cyc(6'h3F, 0, 1, "swp_b2b");
        for (int i = 0; i < 4; i++) cyc(6'h3E, 0, 1, "op_111110");
        cyc(6'h3E, 1, 1, "op_111110_stall");
        for (int i = 0; i < 3; i++) cyc(6'h00, 0, 1, "drain");

        for (int i = 0; i < 600; i++)
            cyc($urandom_range(0, 3) == 0 ? 6'($urandom) : pool[$urandom_range(0, 19)],
                $urandom_range(0, 3) == 0, $urandom_range(0, 31) != 0, "random");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
